// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_XLEN  = 64;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_NRD   = 2;
  localparam int unsigned RF_NWR   = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One zero-latency read port: array value, overridden by same-cycle writes,
// forced to zero for x0 and while the array is still being cleared.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned AW   = $clog2(RF_NREGS),
  parameter int unsigned NWR  = RF_NWR
) (
  input  logic                      run_i,
  input  logic [AW-1:0]             rd_addr_i,
  input  logic [XLEN-1:0]           arr_data_i,
  input  logic [NWR-1:0]            wr_en_i,
  input  logic [NWR-1:0][AW-1:0]    wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
  output logic [XLEN-1:0]           rd_data_c
);

  // Higher-numbered write ports are scanned last so they win the bypass.
  always_comb begin
    rd_data_c = arr_data_i;
    for (int j = 0; j < int'(NWR); j++) begin
      if (wr_en_i[j] && (wr_addr_i[j] == rd_addr_i)) begin
        rd_data_c = wr_data_i[j];
      end
    end
    if (!run_i || (rd_addr_i == '0)) begin
      rd_data_c = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing start-up sequence, x0 hardwired
// to zero and write-through bypass on every read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NRD   = RF_NRD,
  parameter int unsigned NWR   = RF_NWR
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               ready,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD-1:0][XLEN-1:0]           rd_data,
  input  logic [NWR-1:0]                     wr_en,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0]  wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]           wr_data
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q;
  logic          run;

  logic [XLEN-1:0] mem [NREGS];

  assign run   = (state_q == RF_RUN);
  assign ready = ready_q;

  // Next-state: walk the clear index once, then stay operational.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        clr_idx_d = clr_idx_q;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == RF_RUN);
    end
  end

  // Storage has no reset; its contents come only from the clear walk and writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == RF_CLEAR) begin
        mem[clr_idx_q] <= '0;
      end else begin
        for (int j = 0; j < int'(NWR); j++) begin
          if (wr_en[j] && (wr_addr[j] != '0)) begin
            mem[wr_addr[j]] <= wr_data[j];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    regfile_rd_port #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_rd_port (
      .run_i      (run),
      .rd_addr_i  (rd_addr[i]),
      .arr_data_i (mem[rd_addr[i]]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_c  (rd_data[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass, write priority, x0, mid-clear reset.
module tb_regfile_mp;

  logic             clock;
  logic             reset;
  logic             ready;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][63:0] rd_data;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][63:0] wr_data;

  int unsigned total;
  int unsigned passed;

  regfile_mp dut (
    .clock   (clock),
    .reset   (reset),
    .ready   (ready),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 2'b00;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    total++;
    if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready);
    else passed++;
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      rd_addr[0] = 5'd2;
      rd_addr[1] = 5'(e);
      wr_en      = (e < 30) ? 2'b11 : 2'b00;
      wr_addr[0] = 5'd2;
      wr_addr[1] = 5'(e);
      wr_data[0] = 64'hDEAD;
      wr_data[1] = 64'hBEEF;
      #1;
      total++;
      if (rd_data !== '0) $display("FAIL clear_read e=%0d: got %h expected 0", e, rd_data);
      else passed++;
      step();
      total++;
      if (ready !== (e == 32)) $display("FAIL clear_ready e=%0d: got %b expected %b", e, ready, (e == 32));
      else passed++;
    end
    idle_inputs();
    rd_addr[0] = 5'd2;
    rd_addr[1] = 5'd17;
    #1;
    total++;
    if (rd_data !== '0) $display("FAIL clear_writes_lost: got %h expected 0", rd_data);
    else passed++;
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en      = 2'b01;
    wr_addr[0] = 5'd5;
    wr_data[0] = 64'h25;
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd6;
    #1;
    total++;
    if (rd_data[0] !== 64'h25) $display("FAIL bypass_same_cycle: got %h expected 25", rd_data[0]);
    else passed++;
    total++;
    if (rd_data[1] !== 64'h0) $display("FAIL bypass_other_addr: got %h expected 0", rd_data[1]);
    else passed++;
    step();
    wr_en = 2'b00;
    rd_addr[1] = 5'd5;
    #1;
    total++;
    if (rd_data[0] !== 64'h25) $display("FAIL stored_port0: got %h expected 25", rd_data[0]);
    else passed++;
    total++;
    if (rd_data[1] !== 64'h25) $display("FAIL stored_port1: got %h expected 25", rd_data[1]);
    else passed++;
  endtask

  task automatic test_same_addr();
    idle_inputs();
    wr_en      = 2'b11;
    wr_addr[0] = 5'd7;
    wr_addr[1] = 5'd7;
    wr_data[0] = 64'h1111;
    wr_data[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_addr[0] = 5'd7;
    #1;
    total++;
    if (rd_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL prio_bypass: got %h expected ffffffffffffffff", rd_data[0]);
    else passed++;
    step();
    wr_en = 2'b00;
    #1;
    total++;
    if (rd_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL prio_stored: got %h expected ffffffffffffffff", rd_data[0]);
    else passed++;
  endtask

  task automatic test_x0();
    idle_inputs();
    wr_en      = 2'b10;
    wr_addr[1] = 5'd0;
    wr_data[1] = 64'hDEAD;
    rd_addr[0] = 5'd0;
    #1;
    total++;
    if (rd_data[0] !== 64'h0) $display("FAIL x0_bypass: got %h expected 0", rd_data[0]);
    else passed++;
    step();
    wr_en = 2'b00;
    #1;
    total++;
    if (rd_data[0] !== 64'h0) $display("FAIL x0_stored: got %h expected 0", rd_data[0]);
    else passed++;
  endtask

  task automatic test_distinct();
    idle_inputs();
    wr_en      = 2'b11;
    wr_addr[0] = 5'd9;
    wr_addr[1] = 5'd10;
    wr_data[0] = 64'h99;
    wr_data[1] = 64'hAA;
    step();
    wr_en      = 2'b00;
    rd_addr[0] = 5'd10;
    rd_addr[1] = 5'd9;
    #1;
    total++;
    if (rd_data[0] !== 64'hAA) $display("FAIL distinct_p1: got %h expected aa", rd_data[0]);
    else passed++;
    total++;
    if (rd_data[1] !== 64'h99) $display("FAIL distinct_p0: got %h expected 99", rd_data[1]);
    else passed++;
    rd_addr[0] = 5'd7;
    #1;
    total++;
    if (rd_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL retain_r7: got %h expected ffffffffffffffff", rd_data[0]);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    wr_en      = 2'b01;
    wr_addr[0] = 5'd3;
    wr_data[0] = 64'hA;
    step();
    wr_en      = 2'b00;
    rd_addr[0] = 5'd3;
    #1;
    total++;
    if (rd_data[0] !== 64'hA) $display("FAIL load_r3: got %h expected a", rd_data[0]);
    else passed++;
    reset = 1'b1;
    step();
    total++;
    if (ready !== 1'b0) $display("FAIL run_reset_ready: got %b expected 0", ready);
    else passed++;
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    total++;
    if (ready !== 1'b0) $display("FAIL partial_clear_ready: got %b expected 0", ready);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      wr_en      = (e < 30) ? 2'b01 : 2'b00;
      wr_addr[0] = 5'd4;
      wr_data[0] = 64'h44;
      rd_addr[0] = 5'd4;
      rd_addr[1] = 5'd3;
      #1;
      if (e == 5) begin
        total++;
        if (rd_data !== '0) $display("FAIL clear2_read: got %h expected 0", rd_data);
        else passed++;
      end
      step();
      if (e >= 31) begin
        total++;
        if (ready !== (e == 32)) $display("FAIL clear2_ready e=%0d: got %b expected %b", e, ready, (e == 32));
        else passed++;
      end
    end
    idle_inputs();
    rd_addr[0] = 5'd3;
    rd_addr[1] = 5'd4;
    #1;
    total++;
    if (rd_data[0] !== 64'h0) $display("FAIL r3_recleared: got %h expected 0", rd_data[0]);
    else passed++;
    total++;
    if (rd_data[1] !== 64'h0) $display("FAIL r4_clear_write_lost: got %h expected 0", rd_data[1]);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_bypass();
    test_same_addr();
    test_x0();
    test_distinct();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 64, data width of each register.
REQ-002 SHALL provide parameter NREGS, default 32, number of registers (power of two, >=2).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL derive localparam AW = $clog2(NREGS) for the address width.
REQ-006 SHALL have one clock and synchronous, active-high reset: clock  input  1  sole clock, all state updates on posedge.
REQ-007 SHALL have reset  input  1  synchronous active-high reset.
REQ-008 SHALL have ready  output  1  high when the array is initialised and accepting writes.
REQ-009 SHALL have rd_addr  input  [NRD][AW]  read address per read port.
REQ-010 SHALL have rd_data  output  [NRD][XLEN]  read data per read port.
REQ-011 SHALL have wr_en  input  [NWR]  write enable per write port.
REQ-012 SHALL have wr_addr  input  [NWR][AW]  write address per write port.
REQ-013 SHALL have wr_data  input  [NWR][XLEN]  write data per write port.

Function
REQ-014 SHALL implement a two-state FSM: RF_CLEAR (initialising) and RF_RUN (operational).
REQ-015 In RF_CLEAR, each posedge SHALL write zero to register[clr_idx] and increment clr_idx; at clr_idx == NREGS-1, next state SHALL be RF_RUN.
REQ-016 ready SHALL be 1 exactly when state == RF_RUN (registered, no combinational path from inputs).
REQ-017 In RF_CLEAR, all wr_en SHALL be ignored and every rd_data SHALL read 0.
REQ-018 In RF_RUN, read latency SHALL be zero cycles: rd_data[i] is a combinational function of rd_addr[i], the array, and the current-cycle write ports.
REQ-019 Address 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-020 Write-through bypass: if wr_en[j] and wr_addr[j] == rd_addr[i] != 0 in RF_RUN, rd_data[i] SHALL equal wr_data[j] in the same cycle.
REQ-021 Writes SHALL commit at posedge when wr_en[j] and in RF_RUN; the new value is visible from the array the following cycle.
REQ-022 Two write ports to the same non-zero address in one cycle: port NWR-1 SHALL win, for both the committed value and the bypass.
REQ-023 Distinct-address simultaneous writes SHALL both commit.
REQ-024 Address values >= NREGS cannot occur (NREGS power of two); no range check required.

Reset
REQ-025 reset high at a posedge SHALL force state = RF_CLEAR, clr_idx = 0, ready = 0 at that edge.
REQ-026 While reset is held, clr_idx SHALL remain 0 and no register SHALL be cleared.
REQ-027 ready SHALL rise on the NREGS-th posedge after the first edge with reset low (32 edges by default).
REQ-028 reset asserted mid-clear or in RF_RUN SHALL restart the full clear sequence from index 0.
REQ-029 The array itself SHALL carry no reset or initial values; contents are defined solely by the clear sequence.

Structure
REQ-030 Package regfile_pkg SHALL hold the rf_state_t enum {RF_CLEAR, RF_RUN} and default parameter constants (XLEN, NREGS, NRD, NWR).
REQ-031 Sub-module regfile_rd_port SHALL implement one read port (x0 zero, bypass priority, CLEAR masking), instantiated NRD times via generate.
REQ-032 The array SHALL be a single unpacked reg array; no debug $display output in the block.

Verification
REQ-033 reset 1 cycle then low; count edges -> ready 0 for 31 edges, 1 on the 32nd; any rd_addr reads 0 throughout.
REQ-034 RF_RUN: wr port0 addr 5 data 0x25; same cycle rd_addr[0]=5 -> rd_data[0]=0x25 (bypass); next cycle, no write -> still 0x25.
REQ-035 Both ports write addr 7 (port0 0x1111, port1 0xFFFFFFFFFFFFFFFF) -> bypass and stored value = 0xFFFFFFFFFFFFFFFF.
REQ-036 Write addr 0 with 0xDEAD, read addr 0 same and next cycle -> 0 both cycles.
REQ-037 Load addr 3 = 0xA; assert reset at clear index 10, release -> ready after 32 more edges; addr 3 reads 0; write during CLEAR to addr 4 is lost (reads 0 after ready).
